// File: rtl/irig_pkg.sv
// irig_pkg: shared constants and types for the IRIG-B frame generator.
//   - symbol codes driven on irig_data (marker / one / zero / idle)
//   - PWM high widths in milliseconds per symbol
//   - frame length and marker-index test
//   - FSM state type and the latched time-of-year (shadow) record
package irig_pkg;

   localparam logic [2:0] SYM_MARK = 3'b111;
   localparam logic [2:0] SYM_ONE  = 3'b011;
   localparam logic [2:0] SYM_ZERO = 3'b001;
   localparam logic [2:0] SYM_IDLE = 3'b000;

   localparam logic [3:0] W_MARK = 4'd8;
   localparam logic [3:0] W_ONE  = 4'd5;
   localparam logic [3:0] W_ZERO = 4'd2;

   localparam logic [7:0] FRAME_LEN = 8'd100;

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   // BCD digits kept separately so each can be bit-indexed directly.
   typedef struct packed {
      logic [3:0] sec_u;
      logic [2:0] sec_t;
      logic [3:0] min_u;
      logic [2:0] min_t;
      logic [3:0] hr_u;
      logic [1:0] hr_t;
      logic [3:0] day_u;
      logic [3:0] day_t;
      logic [1:0] day_h;
      logic [3:0] yr_u;
      logic [3:0] yr_t;
   } time_t;

   // Position identifiers sit at bit 0 and every bit ending in 9.
   function automatic logic is_marker(input logic [7:0] idx);
      return (idx == 8'd0) || ((idx % 8'd10) == 8'd9);
   endfunction

endpackage

// File: rtl/irig_gen_if.sv
// irig_gen_if: bus between the IRIG-B generator and its user.
//   master: drives en and the time-of-year fields, receives the line outputs
//   slave : the generator side
// Signals: en, sec[6:0], min[6:0], hour[5:0], day[9:0], year[7:0] (only with
// IRIG_GEN_YEAR_EN), irig_data[2:0], irig_out, ind[7:0], frame_start,
// frame_done, busy.
interface irig_gen_if;
   logic       en;
   logic [6:0] sec;
   logic [6:0] min;
   logic [5:0] hour;
   logic [9:0] day;
`ifdef IRIG_GEN_YEAR_EN
   logic [7:0] year;
`endif
   logic [2:0] irig_data;
   logic       irig_out;
   logic [7:0] ind;
   logic       frame_start;
   logic       frame_done;
   logic       busy;

`ifdef IRIG_GEN_YEAR_EN
   modport master (output en, sec, min, hour, day, year,
                   input  irig_data, irig_out, ind, frame_start, frame_done, busy);
   modport slave  (input  en, sec, min, hour, day, year,
                   output irig_data, irig_out, ind, frame_start, frame_done, busy);
`else
   modport master (output en, sec, min, hour, day,
                   input  irig_data, irig_out, ind, frame_start, frame_done, busy);
   modport slave  (input  en, sec, min, hour, day,
                   output irig_data, irig_out, ind, frame_start, frame_done, busy);
`endif
endinterface

// File: rtl/irig_bit_timer.sv
// irig_bit_timer: millisecond and bit-period timebase for the IRIG-B generator.
// Ports:
//   clk, hrd_rst (async, active-high)
//   i_start    : holds/clears both counters (asserted while the generator idles)
//   o_ms_tick  : last clk of each millisecond
//   o_bit_end  : last clk of each 10 ms bit
//   o_bit_pre  : clk just before o_bit_end (lets the parent register a pulse
//                that lands on the last cycle of a bit)
//   o_ms_cnt   : millisecond index inside the bit, 0..9
module irig_bit_timer #(
   parameter int CLK_PER_MS = 100000
) (
   input  logic       clk,
   input  logic       hrd_rst,
   input  logic       i_start,
   output logic       o_ms_tick,
   output logic       o_bit_end,
   output logic       o_bit_pre,
   output logic [3:0] o_ms_cnt
);
   localparam int CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(CLK_PER_MS - 1);
   localparam logic [CW-1:0] C_PRE  = CW'(CLK_PER_MS - 2);

   logic [CW-1:0] r_clk_cnt;
   logic [3:0]    r_ms_cnt;

   assign o_ms_tick = (r_clk_cnt == C_LAST);
   assign o_bit_end = o_ms_tick && (r_ms_cnt == 4'd9);
   assign o_bit_pre = (r_clk_cnt == C_PRE) && (r_ms_cnt == 4'd9);
   assign o_ms_cnt  = r_ms_cnt;

   always_ff @(posedge clk or posedge hrd_rst) begin
      if (hrd_rst) begin
         r_clk_cnt <= '0;
         r_ms_cnt  <= '0;
      end else if (i_start) begin
         r_clk_cnt <= '0;
         r_ms_cnt  <= '0;
      end else if (o_ms_tick) begin
         r_clk_cnt <= '0;
         r_ms_cnt  <= (r_ms_cnt == 4'd9) ? 4'd0 : r_ms_cnt + 4'd1;
      end else begin
         r_clk_cnt <= r_clk_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/irig_gen.sv
// irig_gen: IRIG-B frame generator. Latches a time-of-year and sends it as
// 100-bit frames, one bit per 10 ms, both as a 3-bit symbol code and as a PWM
// line (high 8/5/2 ms for marker/one/zero).
// Ports:
//   clk, hrd_rst (async, active-high)
//   bus : irig_gen_if.slave (en, time fields in; symbol, line, index, pulses out)
// Parameter CLK_PER_MS (>= 2): clk cycles per millisecond.
// Build option IRIG_GEN_YEAR_EN: adds the year field (bits 50-58); without it
// those bits are sent as zeros.
module irig_gen
   import irig_pkg::*;
#(
   parameter int CLK_PER_MS = 100000
) (
   input  logic       clk,
   input  logic       hrd_rst,
   irig_gen_if.slave  bus
);
   state_t     r_state;
   time_t      r_sh;
   logic [7:0] r_ind;
   logic [2:0] r_irig_data;
   logic       r_irig_out;
   logic       r_frame_start;
   logic       r_frame_done;
   logic       r_busy;

   logic       w_ms_tick, w_bit_end, w_bit_pre;
   logic [3:0] w_ms_cnt;
   logic       w_start;
   time_t      w_in;
   logic [7:0] w_nxt_ind;
   logic       w_nxt_bit;
   logic [2:0] w_nxt_sym;
   logic [3:0] w_pwm_w;
   logic       w_fall;

   // Timer is held at zero while idle, so the edge that enters RUN also
   // starts bit 0 from a clean count.
   assign w_start = (r_state == ST_IDLE);

   irig_bit_timer #(.CLK_PER_MS(CLK_PER_MS)) u_tmr (
      .clk       (clk),
      .hrd_rst   (hrd_rst),
      .i_start   (w_start),
      .o_ms_tick (w_ms_tick),
      .o_bit_end (w_bit_end),
      .o_bit_pre (w_bit_pre),
      .o_ms_cnt  (w_ms_cnt)
   );

   always_comb begin
      w_in       = '0;
      w_in.sec_u = bus.sec[3:0];
      w_in.sec_t = bus.sec[6:4];
      w_in.min_u = bus.min[3:0];
      w_in.min_t = bus.min[6:4];
      w_in.hr_u  = bus.hour[3:0];
      w_in.hr_t  = bus.hour[5:4];
      w_in.day_u = bus.day[3:0];
      w_in.day_t = bus.day[7:4];
      w_in.day_h = bus.day[9:8];
`ifdef IRIG_GEN_YEAR_EN
      w_in.yr_u  = bus.year[3:0];
      w_in.yr_t  = bus.year[7:4];
`endif
   end

   // Symbol for the bit that starts after the current one. Only used inside
   // a frame; bit 0 of a new frame is always a marker.
   assign w_nxt_ind = r_ind + 8'd1;

   always_comb begin
      w_nxt_bit = 1'b0;
      case (w_nxt_ind) inside
         [8'd1:8'd4]:   w_nxt_bit = r_sh.sec_u[2'(w_nxt_ind - 8'd1)];
         [8'd6:8'd8]:   w_nxt_bit = r_sh.sec_t[2'(w_nxt_ind - 8'd6)];
         [8'd10:8'd13]: w_nxt_bit = r_sh.min_u[2'(w_nxt_ind - 8'd10)];
         [8'd15:8'd17]: w_nxt_bit = r_sh.min_t[2'(w_nxt_ind - 8'd15)];
         [8'd20:8'd23]: w_nxt_bit = r_sh.hr_u[2'(w_nxt_ind - 8'd20)];
         [8'd25:8'd26]: w_nxt_bit = r_sh.hr_t[1'(w_nxt_ind - 8'd25)];
         [8'd30:8'd33]: w_nxt_bit = r_sh.day_u[2'(w_nxt_ind - 8'd30)];
         [8'd35:8'd38]: w_nxt_bit = r_sh.day_t[2'(w_nxt_ind - 8'd35)];
         [8'd40:8'd41]: w_nxt_bit = r_sh.day_h[1'(w_nxt_ind - 8'd40)];
         [8'd50:8'd53]: w_nxt_bit = r_sh.yr_u[2'(w_nxt_ind - 8'd50)];
         [8'd55:8'd58]: w_nxt_bit = r_sh.yr_t[2'(w_nxt_ind - 8'd55)];
         default:       w_nxt_bit = 1'b0;
      endcase
   end

   assign w_nxt_sym = is_marker(w_nxt_ind) ? SYM_MARK :
                      (w_nxt_bit ? SYM_ONE : SYM_ZERO);

   always_comb begin
      case (r_irig_data)
         SYM_MARK: w_pwm_w = W_MARK;
         SYM_ONE:  w_pwm_w = W_ONE;
         default:  w_pwm_w = W_ZERO;
      endcase
   end

   // Drop the line at the end of ms W-1 so it is low from the first cycle of ms W.
   assign w_fall = w_ms_tick && (w_ms_cnt == (w_pwm_w - 4'd1));

   always_ff @(posedge clk or posedge hrd_rst) begin
      if (hrd_rst) begin
         r_state       <= ST_IDLE;
         r_sh          <= '0;
         r_ind         <= '0;
         r_irig_data   <= SYM_IDLE;
         r_irig_out    <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_done  <= 1'b0;
         r_busy        <= 1'b0;
      end else begin
         r_frame_start <= 1'b0;
         r_frame_done  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.en) begin
                  r_sh          <= w_in;
                  r_state       <= ST_RUN;
                  r_busy        <= 1'b1;
                  r_frame_start <= 1'b1;
                  r_ind         <= '0;
                  r_irig_data   <= SYM_MARK;
                  r_irig_out    <= 1'b1;
               end
            end
            ST_RUN: begin
               // Registered one cycle early so it sits on the last cycle of bit 99.
               if (w_bit_pre && (r_ind == FRAME_LEN - 8'd1))
                  r_frame_done <= 1'b1;
               if (w_fall)
                  r_irig_out <= 1'b0;
               if (w_bit_end) begin
                  if (r_ind == FRAME_LEN - 8'd1) begin
                     r_ind <= '0;
                     if (bus.en) begin
                        r_sh          <= w_in;
                        r_frame_start <= 1'b1;
                        r_irig_data   <= SYM_MARK;
                        r_irig_out    <= 1'b1;
                     end else begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_irig_data <= SYM_IDLE;
                        r_irig_out  <= 1'b0;
                     end
                  end else begin
                     r_ind       <= w_nxt_ind;
                     r_irig_data <= w_nxt_sym;
                     r_irig_out  <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.irig_data   = r_irig_data;
   assign bus.irig_out    = r_irig_out;
   assign bus.ind         = r_ind;
   assign bus.frame_start = r_frame_start;
   assign bus.frame_done  = r_frame_done;
   assign bus.busy        = r_busy;

endmodule

// File: tb/tb_irig_gen.sv
// tb_irig_gen: directed bench for irig_gen with CLK_PER_MS=4 (bit = 40 clks,
// frame = 4000 clks). Expected symbols are queued per frame from the bench's
// own bit map and popped as each bit is observed.
module tb_irig_gen;
   logic clk;
   logic hrd_rst;
   int   n_chk;
   int   n_err;
   logic [2:0] exp_q[$];

   irig_gen_if ifc ();

   irig_gen #(.CLK_PER_MS(4)) dut (
      .clk     (clk),
      .hrd_rst (hrd_rst),
      .bus     (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
      end
   endtask

   task automatic set_time(input logic [6:0] s, input logic [6:0] m, input logic [5:0] h,
                           input logic [9:0] d, input logic [7:0] y);
      ifc.sec  = s;
      ifc.min  = m;
      ifc.hour = h;
      ifc.day  = d;
`ifdef IRIG_GEN_YEAR_EN
      ifc.year = y;
`else
      if (y != 8'h00) ; // year input does not exist in this build
`endif
   endtask

   // Bench bit map: fill data positions field by field, then add markers.
   task automatic push_frame(input logic [6:0] s, input logic [6:0] m, input logic [5:0] h,
                             input logic [9:0] d, input logic [7:0] y);
      logic [99:0] dat;
      dat = '0;
      for (int k = 0; k < 4; k++) begin
         dat[1 + k]  = s[k];
         dat[10 + k] = m[k];
         dat[20 + k] = h[k];
         dat[30 + k] = d[k];
         dat[35 + k] = d[4 + k];
`ifdef IRIG_GEN_YEAR_EN
         dat[50 + k] = y[k];
         dat[55 + k] = y[4 + k];
`endif
      end
      for (int k = 0; k < 3; k++) begin
         dat[6 + k]  = s[4 + k];
         dat[15 + k] = m[4 + k];
      end
      for (int k = 0; k < 2; k++) begin
         dat[25 + k] = h[4 + k];
         dat[40 + k] = d[8 + k];
      end
      for (int b = 0; b < 100; b++) begin
         if (b == 0 || (b % 10) == 9) exp_q.push_back(3'b111);
         else if (dat[b])             exp_q.push_back(3'b011);
         else                         exp_q.push_back(3'b001);
      end
      if (y == 8'hFF) ; // keeps y referenced when the year field is compiled out
   endtask

   task automatic idle_chk(input string t);
      chk({t, "_data"}, 32'(ifc.irig_data), 32'd0);
      chk({t, "_out"},  32'(ifc.irig_out),  32'd0);
      chk({t, "_ind"},  32'(ifc.ind),       32'd0);
      chk({t, "_busy"}, 32'(ifc.busy),      32'd0);
      chk({t, "_fs"},   32'(ifc.frame_start), 32'd0);
      chk({t, "_fd"},   32'(ifc.frame_done),  32'd0);
   endtask

   // Called at #1 after the edge that starts bit 0; returns at #1 after the
   // edge that ends bit 99. mode 1: change time inputs mid-frame; mode 2: drop en.
   task automatic check_frame(input string t, input int mode);
      logic [2:0] e;
      int hi, ew;
      for (int b = 0; b < 100; b++) begin
         if (exp_q.size() == 0) begin
            chk({t, "_q_empty"}, 32'd1, 32'd0);
            e = 3'b000;
         end else e = exp_q.pop_front();
         ew = (e == 3'b111) ? 32 : (e == 3'b011) ? 20 : 8;
         hi = 0;
         for (int c = 0; c < 40; c++) begin
            if (c == 0) begin
               chk($sformatf("%s_sym_b%0d", t, b), 32'(ifc.irig_data), 32'(e));
               chk($sformatf("%s_ind_b%0d", t, b), 32'(ifc.ind), 32'(b));
               chk($sformatf("%s_busy_b%0d", t, b), 32'(ifc.busy), 32'd1);
               chk($sformatf("%s_fs_b%0d", t, b), 32'(ifc.frame_start), 32'(b == 0));
               chk($sformatf("%s_rise_b%0d", t, b), 32'(ifc.irig_out), 32'd1);
            end
            if (c == 38) chk($sformatf("%s_fd_early_b%0d", t, b), 32'(ifc.frame_done), 32'd0);
            if (c == 39) begin
               chk($sformatf("%s_fd_b%0d", t, b), 32'(ifc.frame_done), 32'(b == 99));
               chk($sformatf("%s_fs39_b%0d", t, b), 32'(ifc.frame_start), 32'd0);
               chk($sformatf("%s_low_b%0d", t, b), 32'(ifc.irig_out), 32'd0);
            end
            if (ifc.irig_out === 1'b1) hi++;
            if (b == 50 && c == 5) begin
               if (mode == 1) set_time(7'h05, 7'h58, 6'h09, 10'h001, 8'h07);
               if (mode == 2) ifc.en = 1'b0;
            end
            @(posedge clk); #1;
         end
         chk($sformatf("%s_pwm_b%0d", t, b), 32'(hi), 32'(ew));
      end
   endtask

   initial begin
      int n;
      n_chk = 0;
      n_err = 0;
      hrd_rst = 1'b1;
      ifc.en = 1'b0;
      set_time(7'h59, 7'h07, 6'h23, 10'h365, 8'h24);
      repeat (3) @(posedge clk);
      #1;
      idle_chk("rst");
      hrd_rst = 1'b0;

      // Idle with en low for 100 cycles.
      repeat (100) @(posedge clk);
      #1;
      idle_chk("idle");

      // Single frame from a one-cycle en pulse.
      ifc.en = 1'b1;
      push_frame(7'h59, 7'h07, 6'h23, 10'h365, 8'h24);
      @(posedge clk); #1;
      ifc.en = 1'b0;
      check_frame("f1", 0);
      idle_chk("f1_end");

      // Continuous run: frame 2 with inputs changed mid-frame, frame 3 back-to-back.
      set_time(7'h31, 7'h45, 6'h12, 10'h128, 8'h99);
      ifc.en = 1'b1;
      push_frame(7'h31, 7'h45, 6'h12, 10'h128, 8'h99);
      @(posedge clk); #1;
      check_frame("f2", 1);
      push_frame(7'h05, 7'h58, 6'h09, 10'h001, 8'h07);
      check_frame("f3", 2);
      idle_chk("f3_end");

      // Reset in the middle of a frame.
      set_time(7'h12, 7'h34, 6'h05, 10'h299, 8'h24);
      ifc.en = 1'b1;
      @(posedge clk); #1;
      n = 0;
      while (ifc.ind !== 8'd37 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("reach_ind37", 32'(ifc.ind), 32'd37);
      hrd_rst = 1'b1;
      #1;
      idle_chk("midrst");
      #2;
      hrd_rst = 1'b0;
      push_frame(7'h12, 7'h34, 6'h05, 10'h299, 8'h24);
      @(posedge clk); #1;
      ifc.en = 1'b0;
      check_frame("f4", 0);
      idle_chk("f4_end");

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
